// File: rtl/dma_arbiter_pkg.sv
// Shared types and default constants for the DMA bus arbiter.
package pa_dma;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_BUS = 2'd1,
        GRANTED = 2'd2,
        RELEASE = 2'd3
    } dma_arb_state_t;

    localparam int DMA_NUM_CH_DEF    = 4;
    localparam int DMA_BURST_MAX_DEF = 16;

endpackage

// File: rtl/dma_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int NUM_CH = 4,
    parameter int IW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IW-1:0]     rr_ptr,
    output logic              valid,
    output logic [IW-1:0]     idx
);

    int          s;
    logic [IW-1:0] c;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        s     = 0;
        c     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // rr_ptr < NUM_CH always, so a single subtract is a full wrap
            s = int'(rr_ptr) + i;
            if (s >= NUM_CH) s = s - NUM_CH;
            c = IW'(s);
            if (!valid && req[c]) begin
                valid = 1'b1;
                idx   = c;
            end
        end
    end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin DMA arbiter handshaking bus ownership with the CPU (dma_req/dma_ack).
// Optional per-tenure burst limit enabled by defining DMA_BURST_LIMIT_EN.
module dma_arbiter
    import pa_dma::*;
#(
    parameter int NUM_CH    = DMA_NUM_CH_DEF,
    parameter int BURST_MAX = DMA_BURST_MAX_DEF
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [NUM_CH-1:0]         req,
    output logic [NUM_CH-1:0]         grant,
    output logic                      cpu_dma_req,
    input  logic                      cpu_dma_ack,
    output logic [$clog2(NUM_CH)-1:0] active_ch,
    output logic                      busy,
    output logic                      preempt
);

    localparam int IW = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 8 || BURST_MAX < 2 || BURST_MAX > 256) begin : g_param_chk
        $error("dma_arbiter: NUM_CH or BURST_MAX out of range");
    end

    dma_arb_state_t    state_q, state_d;
    logic [IW-1:0]     rr_ptr, rr_d, active_d;
    logic [NUM_CH-1:0] grant_d;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;

    rr_picker #(.NUM_CH(NUM_CH), .IW(IW)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

`ifdef DMA_BURST_LIMIT_EN
    localparam int CW = $clog2(BURST_MAX);
    logic [CW-1:0] tenure_cnt;
    logic          burst_done;
    logic          preempt_d;

    assign burst_done = (state_q == GRANTED) && (tenure_cnt == CW'(BURST_MAX - 1));

    // Zero on the first GRANTED cycle, counts every GRANTED cycle after that
    always_ff @(posedge clk) begin
        if (arst || state_q != GRANTED) tenure_cnt <= '0;
        else                            tenure_cnt <= tenure_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (arst) preempt <= 1'b0;
        else      preempt <= preempt_d;
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        active_d = active_ch;
        rr_d     = rr_ptr;
`ifdef DMA_BURST_LIMIT_EN
        preempt_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = REQ_BUS;
                    active_d = pick_idx;
                end
            end
            // A dropped request beats a same-cycle ack: the tenure is aborted
            REQ_BUS: begin
                if (!req[active_ch])  state_d = RELEASE;
                else if (cpu_dma_ack) state_d = GRANTED;
            end
            GRANTED: begin
                if (!req[active_ch]) state_d = RELEASE;
`ifdef DMA_BURST_LIMIT_EN
                else if (burst_done) begin
                    state_d   = RELEASE;
                    preempt_d = 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (!cpu_dma_ack) begin
                    state_d = IDLE;
                    rr_d    = (active_ch == IW'(NUM_CH - 1)) ? '0 : active_ch + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        grant_d = '0;
        if (state_d == GRANTED) grant_d[active_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q     <= IDLE;
            active_ch   <= '0;
            rr_ptr      <= '0;
            grant       <= '0;
            cpu_dma_req <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_ch   <= active_d;
            rr_ptr      <= rr_d;
            grant       <= grant_d;
            cpu_dma_req <= (state_d == REQ_BUS) || (state_d == GRANTED);
            busy        <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter; grant winners are checked against a scoreboard queue.
module tb_dma_arbiter;

    logic       clk = 1'b0;
    logic       arst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       cpu_dma_req;
    logic       cpu_dma_ack;
    logic [1:0] active_ch;
    logic       busy;
    logic       preempt;

    int vectors = 0;
    int errors  = 0;

    logic [3:0] exp_q[$];
    logic [3:0] prev_g;
    logic [3:0] e;

    always #5 clk = ~clk;

    dma_arbiter #(.NUM_CH(4), .BURST_MAX(4)) dut (
        .clk         (clk),
        .arst        (arst),
        .req         (req),
        .grant       (grant),
        .cpu_dma_req (cpu_dma_req),
        .cpu_dma_ack (cpu_dma_ack),
        .active_ch   (active_ch),
        .busy        (busy),
        .preempt     (preempt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rising grant must match the next expected winner
    always @(negedge clk) begin
        if (!arst) begin
            chk("grant_onehot", 32'($onehot0(grant)), 32'd1);
            if (grant != 4'b0 && prev_g == 4'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", {28'd0, grant}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_winner", {28'd0, grant}, {28'd0, e});
                end
            end
        end
        prev_g <= grant;
    end

    // Raise r, wait for cpu_dma_req, ack, wait for the first grant cycle
    task automatic start_grant(input logic [3:0] r, input logic [3:0] exp_g);
        bit seen;
        exp_q.push_back(exp_g);
        req  = r;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = cpu_dma_req;
        end
        chk("req_timeout", 32'(seen), 32'd1);
        cpu_dma_ack = 1'b1;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = (grant != 4'b0);
        end
        chk("grant_timeout", 32'(seen), 32'd1);
    endtask

    // Full tenure: gcycles GRANTED cycles, drop the winner's req, hand the bus back
    task automatic tenure(input logic [3:0] r, input int gcycles, input logic [3:0] exp_g);
        start_grant(r, exp_g);
        for (int i = 1; i < gcycles; i++) tick();
        req = r & ~exp_g;
        tick();
        chk("release_grant", {28'd0, grant}, 32'd0);
        chk("release_cpu_req", 32'(cpu_dma_req), 32'd0);
        cpu_dma_ack = 1'b0;
        req = r;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int good;
        int gcnt;
        int pcnt;
        arst = 1'b1; req = 4'b0; cpu_dma_ack = 1'b0; prev_g = 4'b0;
        tick(); tick();
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_cpu_req", 32'(cpu_dma_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_active", 32'(active_ch), 32'd0);
        chk("rst_preempt", 32'(preempt), 32'd0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        arst = 1'b0;
        tick();

        // Single request, ack three cycles after cpu_dma_req
        exp_q.push_back(4'b0100);
        req = 4'b0100;
        tick();
        chk("single_cpu_req", 32'(cpu_dma_req), 32'd1);
        chk("single_active", 32'(active_ch), 32'd2);
        chk("single_busy", 32'(busy), 32'd1);
        tick(); tick();
        chk("single_no_early_grant", {28'd0, grant}, 32'd0);
        cpu_dma_ack = 1'b1;
        tick();
        chk("single_grant", {28'd0, grant}, 32'h4);
        tick(); tick();
        req = 4'b0;
        tick();
        chk("single_rel_grant", {28'd0, grant}, 32'd0);
        chk("single_rel_busy", 32'(busy), 32'd1);
        cpu_dma_ack = 1'b0;
        tick();
        chk("single_idle_busy", 32'(busy), 32'd0);
        chk("single_rr_ptr", 32'(dut.rr_ptr), 32'd3);

        // Fairness from a fresh pointer
        arst = 1'b1; tick(); arst = 1'b0;
        tenure(4'b1111, 5, 4'b0001);
        tenure(4'b1111, 5, 4'b0010);
        tenure(4'b1111, 5, 4'b0100);
        tenure(4'b1111, 5, 4'b1000);
        tenure(4'b1111, 5, 4'b0001);
        req = 4'b0;
        tick();

        // Abort: request drops on the same cycle the ack arrives
        req = 4'b0010;
        tick();
        chk("abort_active", 32'(active_ch), 32'd1);
        chk("abort_cpu_req_up", 32'(cpu_dma_req), 32'd1);
        req = 4'b0; cpu_dma_ack = 1'b1;
        tick();
        chk("abort_cpu_req_down", 32'(cpu_dma_req), 32'd0);
        chk("abort_grant", {28'd0, grant}, 32'd0);
        tick();
        chk("abort_wait_ack", 32'(busy), 32'd1);
        cpu_dma_ack = 1'b0;
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_rr_ptr", 32'(dut.rr_ptr), 32'd2);

        // Reset in the middle of a tenure
        start_grant(4'b0100, 4'b0100);
        tick();
        arst = 1'b1;
        tick();
        chk("midrst_grant", {28'd0, grant}, 32'd0);
        chk("midrst_cpu_req", 32'(cpu_dma_req), 32'd0);
        chk("midrst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        arst = 1'b0; cpu_dma_ack = 1'b0;
        tenure(4'b1000, 3, 4'b1000);
        req = 4'b0;
        tick();

`ifdef DMA_BURST_LIMIT_EN
        // Burst limit of 4 with the request held
        start_grant(4'b0001, 4'b0001);
        gcnt = 1; pcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pcnt += int'(preempt);
            if (grant == 4'b0) break;
            gcnt++;
        end
        tick();
        pcnt += int'(preempt);
        chk("burst_len", 32'(gcnt), 32'd4);
        chk("burst_preempt_pulses", 32'(pcnt), 32'd1);
        cpu_dma_ack = 1'b0;
        tick();
        chk("burst_rr_ptr", 32'(dut.rr_ptr), 32'd1);
        start_grant(4'b0001, 4'b0001);
`else
        // No limit: the grant stays put for 300 cycles
        start_grant(4'b0001, 4'b0001);
        good = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (grant === 4'b0001 && preempt === 1'b0) good++;
        end
        chk("hold_300", 32'(good), 32'd300);
`endif
        req = 4'b0;
        tick();
        cpu_dma_ack = 1'b0;
        tick();
        chk("final_idle", 32'(busy), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of DMA requester channels (2..8).
REQ-002 Parameter BURST_MAX, default 16: maximum GRANTED cycles per tenure when DMA_BURST_LIMIT_EN is defined (2..256).
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 arst  input  1  reset, synchronous and active-high.
REQ-005 req  input  NUM_CH  per-channel bus request; the channel holds it high for its whole transfer.
REQ-006 grant  output  NUM_CH  one-hot bus grant to the winning channel.
REQ-007 cpu_dma_req  output  1  connects to the CPU dma_req pin.
REQ-008 cpu_dma_ack  input  1  connects to the CPU dma_ack pin; high means the CPU has floated the bus.
REQ-009 active_ch  output  $clog2(NUM_CH)  index of the current or last winner.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 preempt  output  1  one-cycle pulse when a tenure is ended by the burst limit.

Function
REQ-012 FSM states SHALL be IDLE, REQ_BUS, GRANTED and RELEASE; all outputs SHALL be registered.
REQ-013 IDLE: when any req bit is high, the block SHALL latch the round-robin winner into active_ch, go to REQ_BUS, and raise cpu_dma_req on the next cycle (1-cycle latency).
REQ-014 Round-robin: the search SHALL start at index rr_ptr and wrap through NUM_CH-1 to 0; the first set req bit wins.
REQ-015 REQ_BUS: cpu_dma_req SHALL stay high; when cpu_dma_ack is sampled high, the block SHALL go to GRANTED, with grant[active_ch] high the next cycle.
REQ-016 REQ_BUS abort: if req[active_ch] drops before ack, the block SHALL drop cpu_dma_req and go to RELEASE; a simultaneous ack and drop SHALL count as an abort.
REQ-017 GRANTED: grant SHALL be one-hot at active_ch and cpu_dma_req SHALL stay high; when req[active_ch] is sampled low, the block SHALL go to RELEASE, with grant and cpu_dma_req low the next cycle.
REQ-018 GRANTED: a cpu_dma_ack drop SHALL be ignored (the CPU holds ack while req is high).
REQ-019 RELEASE: grant SHALL be 0 and cpu_dma_req 0; when cpu_dma_ack is sampled low, the block SHALL set rr_ptr to (active_ch+1) mod NUM_CH and go to IDLE.
REQ-020 A new request SHALL NOT be serviced until ack has been seen low, so there is no back-to-back grant without a bus handover.
REQ-021 Requests from non-winning channels SHALL be ignored outside IDLE; req bits SHALL NOT be latched.
REQ-022 grant SHALL never have more than one bit set and SHALL be nonzero only in GRANTED.

Reset
REQ-023 While arst is high, the state SHALL be IDLE and grant, cpu_dma_req, busy, preempt, active_ch and rr_ptr SHALL be 0.
REQ-024 Reset mid-tenure SHALL drop grant and cpu_dma_req on the first clock edge with arst high; no RELEASE handshake is performed.

Configuration
REQ-025 Macro DMA_BURST_LIMIT_EN, when defined, SHALL add a tenure counter that clears on entry to GRANTED and increments each GRANTED cycle.
REQ-026 With the macro defined, when the counter reaches BURST_MAX-1 the block SHALL go to RELEASE, pulse preempt for one cycle, and advance rr_ptr, even if req[active_ch] is still high.
REQ-027 Without the macro, the tenure SHALL be unlimited, preempt SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-028 The state enum type dma_arb_state_t SHALL live in the shared package pa_testbench-adjacent design package pa_dma.
REQ-029 The default constants DMA_NUM_CH_DEF and DMA_BURST_MAX_DEF SHALL live in pa_dma.
REQ-030 The round-robin priority picker SHALL be one sub-module, rr_picker, taking (req, rr_ptr) and returning (valid, idx); it is purely combinational.

Verification
REQ-031 Single request: assert req=4'b0100 at cycle 0 and ack 3 cycles after cpu_dma_req -> cpu_dma_req high at cycle 1, grant=4'b0100 one cycle after ack, active_ch=2.
REQ-032 Fairness: hold req=4'b1111 for all tenures, each dropped after 5 GRANTED cycles -> grant order ch0, ch1, ch2, ch3, ch0, with ack low between tenures.
REQ-033 Abort: req[1] drops while in REQ_BUS before ack -> cpu_dma_req low the next cycle, grant never set, state returns to IDLE after ack low.
REQ-034 Burst limit (macro defined, BURST_MAX=4): req=4'b0001 held high -> grant held exactly 4 cycles, preempt pulses once, then re-arbitration re-grants ch0 after the ack handover.
REQ-035 Reset mid-GRANTED: assert arst for 1 cycle -> grant=0, cpu_dma_req=0, rr_ptr=0 on the next edge; a fresh req=4'b1000 then wins.
REQ-036 Without the macro, hold req=4'b0001 for 300 cycles -> grant is held continuously and preempt stays 0.
